// File: rtl/sin_ctrl_pkg.sv
// Shared definitions for the sine-datapath sweep control: FSM state encoding
// and default bus widths used by the datapath, sequencer and harness.
package sin_ctrl_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_DONE    = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/sin_sweep_sequencer.sv
// Sweeps the sine datapath input across [start_code, end_code] in step
// increments, settles, captures the output and streams (code, value) pairs.
module sin_sweep_sequencer
  import sin_ctrl_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  start_code,
  input  logic [IN_W-1:0]  end_code,
  input  logic [IN_W-1:0]  step,
  output logic [IN_W-1:0]  dut_digital,
  input  logic [OUT_W-1:0] dut_analog,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IN_W-1:0]  res_code,
  output logic [OUT_W-1:0] res_value,
  output logic [IN_W:0]    res_count,
  output logic             busy,
  output logic             done
);

  sweep_state_t    state;
  logic [7:0]      settle_cnt;
  logic [IN_W-1:0] end_q;
  logic [IN_W-1:0] step_q;
  logic [IN_W:0]   next_code;

  // One extra bit so a sweep ending at the top code terminates on the carry
  // instead of wrapping dut_digital back to zero.
  assign next_code = {1'b0, dut_digital} + {1'b0, step_q};

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Result handshake: res_valid rises only on capture, and res_valid,
  // res_code and res_value stay frozen until a cycle with
  // res_valid && res_ready; res_ready while res_valid is low does nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      end_q       <= '0;
      step_q      <= '0;
      dut_digital <= '0;
      res_valid   <= 1'b0;
      res_code    <= '0;
      res_value   <= '0;
      res_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            end_q     <= end_code;
            step_q    <= (step == '0) ? IN_W'(1) : step;
            res_count <= '0;
            if (start_code > end_code) begin
              state <= ST_DONE;
            end else begin
              dut_digital <= start_code;
              settle_cnt  <= '0;
              state       <= ST_DRIVE;
            end
          end
        end

        ST_DRIVE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == 8'(SETTLE - 1)) begin
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          res_value <= dut_analog;
          res_code  <= dut_digital;
          res_valid <= 1'b1;
          state     <= ST_OUTPUT;
        end

        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_count <= res_count + (IN_W+1)'(1);
            if (next_code > {1'b0, end_q}) begin
              state <= ST_DONE;
            end else begin
              dut_digital <= next_code[IN_W-1:0];
              settle_cnt  <= '0;
              state       <= ST_DRIVE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_sweep_sequencer.sv
// Bench for sin_sweep_sequencer: directed sweep table, stall/reset sequences
// and random sweeps checked against a list-of-codes reference model.
module tb_sin_sweep_sequencer;

  localparam int IN_W   = 12;
  localparam int OUT_W  = 6;
  localparam int SETTLE = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  start_code;
  logic [IN_W-1:0]  end_code;
  logic [IN_W-1:0]  step;
  logic [IN_W-1:0]  dut_digital;
  logic [OUT_W-1:0] dut_analog;
  logic             res_valid;
  logic             res_ready;
  logic [IN_W-1:0]  res_code;
  logic [OUT_W-1:0] res_value;
  logic [IN_W:0]    res_count;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int model_last = 0;
  logic [IN_W-1:0] exp_q[$];

  sin_sweep_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .start_code(start_code),
    .end_code(end_code), .step(step), .dut_digital(dut_digital),
    .dut_analog(dut_analog), .res_valid(res_valid), .res_ready(res_ready),
    .res_code(res_code), .res_value(res_value), .res_count(res_count),
    .busy(busy), .done(done)
  );

  // clock / reset block and registered datapath stand-in
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) dut_analog <= dut_digital[OUT_W-1:0];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: the ordered list of codes a sweep must report
  task automatic build_model(input int s, input int e, input int st);
    int eff;
    eff = (st == 0) ? 1 : st;
    exp_q.delete();
    for (int c = s; c <= e; c += eff) exp_q.push_back(IN_W'(c));
    if (exp_q.size() > 0) model_last = int'(exp_q[exp_q.size()-1]);
  endtask

  task automatic pulse_random_start();
    start      = 1'b1;
    start_code = IN_W'($urandom_range(0, 4095));
    end_code   = IN_W'($urandom_range(0, 4095));
    step       = IN_W'($urandom_range(0, 4095));
  endtask

  // driver + monitor for one sweep; samples on the falling edge
  task automatic run_sweep(input int s, input int e, input int st, input int ready_pct,
                           input int stall_code, input int exp_count, input int exp_last,
                           input int exp_done_i, input bit noisy_start);
    int exp_n, n_got, first_valid, done_i, stall_left;
    bit got_done, holding;
    logic [IN_W-1:0]  held_code, want;
    logic [OUT_W-1:0] held_val;
    build_model(s, e, st);
    exp_n = exp_q.size();
    n_got = 0; first_valid = -1; done_i = -1; stall_left = 5;
    got_done = 0; holding = 0;
    held_code = '0; held_val = '0;
    @(negedge clk);
    start = 1'b1; start_code = IN_W'(s); end_code = IN_W'(e); step = IN_W'(st);
    for (int i = 0; i < 4000 && !got_done; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) check("busy_after_start", busy, 1);
      if (holding) begin
        check("valid_held", res_valid, 1);
        check("code_held", res_code, held_code);
        check("value_held", res_value, held_val);
        holding = 0;
      end
      if (stall_code >= 0 && res_valid && res_code == IN_W'(stall_code) && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
        pulse_random_start();
      end else begin
        res_ready = ($urandom_range(0, 99) < ready_pct);
        if (noisy_start && !done && $urandom_range(0, 9) == 0) pulse_random_start();
      end
      if (res_valid) begin
        if (first_valid < 0) first_valid = i;
        check("digital_stable", dut_digital, res_code);
        if (res_ready) begin
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("res_code", res_code, want);
          check("res_value", res_value, want[OUT_W-1:0]);
          n_got++;
        end else begin
          holding = 1; held_code = res_code; held_val = res_value;
        end
      end
      if (done) begin
        got_done = 1;
        done_i = i;
        pulse_random_start();
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("result_count", n_got, exp_n);
    if (exp_count >= 0) check("table_count", n_got, exp_count);
    check("res_count", res_count, exp_n);
    if (exp_done_i >= 0) check("done_cycle", done_i, exp_done_i);
    if (exp_done_i >= 0 && exp_n > 0) check("first_latency", first_valid, SETTLE + 1);
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    check("idle_busy", busy, 0);
    check("done_one_cycle", done, 0);
    check("count_hold", res_count, exp_n);
    check("digital_hold", dut_digital, (exp_last >= 0) ? exp_last : model_last);
  endtask

  typedef struct {
    int s; int e; int st; int stall; int exp_count; int exp_last; int exp_done_i;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int s, e, st;
    rst = 1'b1; start = 1'b0; start_code = '0; end_code = '0; step = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_digital", dut_digital, 0);
    check("rst_valid", res_valid, 0);
    check("rst_code", res_code, 0);
    check("rst_value", res_value, 0);
    check("rst_count", res_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    vecs[0] = '{s: 0,    e: 3,    st: 1,  stall: -1, exp_count: 4, exp_last: 3,    exp_done_i: 16};
    vecs[1] = '{s: 100,  e: 130,  st: 10, stall: -1, exp_count: 4, exp_last: 130,  exp_done_i: 16};
    vecs[2] = '{s: 4094, e: 4095, st: 1,  stall: -1, exp_count: 2, exp_last: 4095, exp_done_i: 8};
    vecs[3] = '{s: 5,    e: 2,    st: 1,  stall: -1, exp_count: 0, exp_last: 4095, exp_done_i: 0};
    vecs[4] = '{s: 7,    e: 9,    st: 0,  stall: -1, exp_count: 3, exp_last: 9,    exp_done_i: 12};
    vecs[5] = '{s: 0,    e: 3,    st: 1,  stall: 1,  exp_count: 4, exp_last: 3,    exp_done_i: -1};
    for (int v = 0; v < 6; v++)
      run_sweep(vecs[v].s, vecs[v].e, vecs[v].st, 100, vecs[v].stall,
                vecs[v].exp_count, vecs[v].exp_last, vecs[v].exp_done_i, 1'b0);

    // reset while driving code 2 of a 0..3 sweep
    @(negedge clk);
    start = 1'b1; start_code = IN_W'(0); end_code = IN_W'(3); step = IN_W'(1); res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dut_digital == IN_W'(2) && !res_valid && busy) break;
      @(negedge clk);
    end
    check("reached_code2", dut_digital, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_digital", dut_digital, 0);
    check("abort_valid", res_valid, 0);
    check("abort_code", res_code, 0);
    check("abort_value", res_value, 0);
    check("abort_count", res_count, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    model_last = 0;
    run_sweep(0, 3, 1, 100, -1, 4, 3, 16, 1'b0);

    // random sweeps, random back-pressure and ignored start pulses
    for (int r = 0; r < 15; r++) begin
      s  = $urandom_range(0, 4095);
      e  = s + $urandom_range(0, 60);
      if (e > 4095) e = 4095;
      if ($urandom_range(0, 6) == 0) e = s - $urandom_range(1, 20);
      if (e < 0) e = 0;
      st = $urandom_range(0, 8);
      run_sweep(s, e, st, 60, -1, -1, -1, -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
